// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
// Transmit stage of the AXI-to-UART bridge. Accepts one byte at a time over a
// valid/ready handshake and serializes it as start, N data bits (LSB first),
// optional parity and one or two stop bits. Each bit lasts cfg_clk_div clocks.
// The frame configuration is captured at accept time, so the register block
// may change cfg_* while a frame is on the line without corrupting it.
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int DIV_WIDTH     = 16,
    parameter int DATA_BITS_MAX = 8
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic [DATA_BITS_MAX-1:0] s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     cfg_parity_en,
    input  logic                     cfg_parity_type,
    input  logic [3:0]               cfg_num_data_bits,
    input  logic [1:0]               cfg_num_stop_bits,
    input  logic [DIV_WIDTH-1:0]     cfg_clk_div,
    output logic                     tx,
    output logic                     busy,
    output logic                     tx_done
);

    localparam int IDX_W = (DATA_BITS_MAX > 1) ? $clog2(DATA_BITS_MAX) : 1;

    localparam logic [3:0]           N_MIN   = 4'd5;
    localparam logic [3:0]           N_MAX   = 4'(DATA_BITS_MAX);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Frame shadow registers, loaded only on accept.
    logic [DATA_BITS_MAX-1:0] data_q, data_d;
    logic                     par_en_q, par_en_d;
    logic                     par_type_q, par_type_d;
    logic [IDX_W-1:0]         last_idx_q, last_idx_d;   // N-1
    logic                     two_stop_q, two_stop_d;   // S-1
    logic [DIV_WIDTH-1:0]     div_m1_q, div_m1_d;       // D-1

    // Sequencing state.
    state_t                   state_q, state_d;
    logic [DIV_WIDTH-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]         bit_idx_q, bit_idx_d;
    logic                     stop_idx_q, stop_idx_d;

    // Registered outputs.
    logic                     tx_q, tx_d;
    logic                     busy_q, busy_d;
    logic                     ready_q, ready_d;
    logic                     done_q, done_d;

    // Accept-time normalization of the configuration inputs.
    logic [IDX_W-1:0]         cfg_last_idx;
    logic [DIV_WIDTH-1:0]     cfg_div_m1;
    logic                     cfg_two_stop;
    logic                     accept;
    logic                     parity_bit;

    assign accept = s_valid && ready_q;

    // Clamp the data-bit count, floor the divider at 1 and fold the stop-bit count.
    always_comb begin
        // NOTE: every signal written in an always_comb gets a value on every
        // path (defaults first); a missed branch would otherwise infer a latch.
        cfg_last_idx = IDX_W'(N_MAX - 4'd1);
        if (cfg_num_data_bits < N_MIN) begin
            cfg_last_idx = IDX_W'(N_MIN - 4'd1);
        end else if (cfg_num_data_bits <= N_MAX) begin
            cfg_last_idx = IDX_W'(cfg_num_data_bits - 4'd1);
        end

        cfg_div_m1   = (cfg_clk_div == '0) ? '0 : (cfg_clk_div - DIV_ONE);
        cfg_two_stop = (cfg_num_stop_bits >= 2'd2);
    end

    // Parity over the transmitted bits only, inverted for odd parity.
    always_comb begin
        parity_bit = par_type_q;
        for (int i = 0; i < DATA_BITS_MAX; i++) begin
            if (IDX_W'(i) <= last_idx_q) begin
                parity_bit = parity_bit ^ data_q[i];
            end
        end
    end

    // Next-state logic; outputs are derived from the next state so they register
    // in step with it (first start-bit cycle directly follows the accept edge).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        last_idx_d = last_idx_q;
        two_stop_d = two_stop_q;
        div_m1_d   = div_m1_q;

        tx_d       = 1'b1;
        busy_d     = 1'b1;
        ready_d    = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d     = s_data;
                    par_en_d   = cfg_parity_en;
                    par_type_d = cfg_parity_type;
                    last_idx_d = cfg_last_idx;
                    two_stop_d = cfg_two_stop;
                    div_m1_d   = cfg_div_m1;
                    cnt_d      = cfg_div_m1;
                    state_d    = START;
                end
            end

            START: begin
                if (cnt_q == '0) begin
                    cnt_d     = div_m1_q;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt_q - DIV_ONE;
                end
            end

            DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = div_m1_q;
                    if (bit_idx_q == last_idx_q) begin
                        stop_idx_d = 1'b0;
                        state_d    = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_ONE;
                end
            end

            PARITY: begin
                if (cnt_q == '0) begin
                    cnt_d      = div_m1_q;
                    stop_idx_d = 1'b0;
                    state_d    = STOP;
                end else begin
                    cnt_d = cnt_q - DIV_ONE;
                end
            end

            STOP: begin
                if (cnt_q == '0) begin
                    if (stop_idx_q == two_stop_q) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d      = div_m1_q;
                        stop_idx_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_ONE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        case (state_d)
            IDLE: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_q[bit_idx_d];
            PARITY:  tx_d = parity_bit;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase

        done_d = (state_q == STOP) && (state_d == IDLE);
    end

    // State, shadow and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            last_idx_q <= '0;
            two_stop_q <= 1'b0;
            div_m1_q   <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            last_idx_q <= last_idx_d;
            two_stop_q <= two_stop_d;
            div_m1_q   <= div_m1_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign s_ready = ready_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_serializer
// Self-checking bench: each scenario drives bytes and compares the serial
// line cycle by cycle against a frame model built from the framing rules.
// ---------------------------------------------------------------------------
module tb_uart_tx_serializer;

    logic        clk = 1'b0;
    logic        arst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        cfg_parity_en;
    logic        cfg_parity_type;
    logic [3:0]  cfg_num_data_bits;
    logic [1:0]  cfg_num_stop_bits;
    logic [15:0] cfg_clk_div;
    logic        tx;
    logic        busy;
    logic        tx_done;

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected tx level for every clock of one frame (start through last stop).
    bit exp_tx[$];

    uart_tx_serializer #(
        .DIV_WIDTH     (16),
        .DATA_BITS_MAX (8)
    ) dut (
        .clk               (clk),
        .arst              (arst),
        .s_data            (s_data),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .cfg_parity_en     (cfg_parity_en),
        .cfg_parity_type   (cfg_parity_type),
        .cfg_num_data_bits (cfg_num_data_bits),
        .cfg_num_stop_bits (cfg_num_stop_bits),
        .cfg_clk_div       (cfg_clk_div),
        .tx                (tx),
        .busy              (busy),
        .tx_done           (tx_done)
    );

    always #5 clk = ~clk;

    // Frame model: start, N data bits LSB first, optional parity, S stop bits,
    // each repeated D times.
    function automatic void build_frame(input logic [7:0] d, input logic pen,
                                        input logic ptype, input logic [3:0] nb,
                                        input logic [1:0] sb, input logic [15:0] div);
        int dd;
        int n;
        int s;
        int ones;
        bit pbit;
        dd = (div == 16'd0) ? 1 : int'(div);
        n  = int'(nb);
        if (n < 5) n = 5;
        if (n > 8) n = 8;
        s  = (int'(sb) >= 2) ? 2 : 1;
        ones = 0;
        exp_tx.delete();
        repeat (dd) exp_tx.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            if (d[i]) ones++;
            repeat (dd) exp_tx.push_back(d[i]);
        end
        if (pen) begin
            pbit = (ones % 2 == 1) ? ~ptype : ptype;
            repeat (dd) exp_tx.push_back(pbit);
        end
        repeat (s * dd) exp_tx.push_back(1'b1);
    endfunction

    // Present a byte and configuration, wait for the accepting edge.
    task automatic accept_byte(input logic [7:0] d, input logic pen, input logic ptype,
                               input logic [3:0] nb, input logic [1:0] sb,
                               input logic [15:0] div, input bit hold);
        int waited = 0;
        @(negedge clk);
        while (s_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (s_ready !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL accept_timeout: s_ready=%b after %0d cycles, expected 1", s_ready, waited);
        end
        s_data            = d;
        cfg_parity_en     = pen;
        cfg_parity_type   = ptype;
        cfg_num_data_bits = nb;
        cfg_num_stop_bits = sb;
        cfg_clk_div       = div;
        s_valid           = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) s_valid = 1'b0;
    endtask

    task automatic test_reset();
        arst    = 1'b1;
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (tx !== 1'b1) begin tests_failed++; $display("FAIL reset_tx: got %b, expected 1", tx); end
        tests_run++;
        if (s_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b, expected 1", s_ready); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        tests_run++;
        if (tx_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b, expected 0", tx_done); end
    endtask

    task automatic test_8n1();
        bit exp_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        accept_byte(8'hA5, 1'b0, 1'b0, 4'd8, 2'd1, 16'd4, 1'b0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            tests_run++;
            if (tx !== exp_bits[c / 4] || busy !== 1'b1 || tx_done !== 1'b0 || s_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL 8n1 cycle %0d: tx=%b busy=%b done=%b rdy=%b, expected tx=%b busy=1 done=0 rdy=0",
                         c, tx, busy, tx_done, s_ready, exp_bits[c / 4]);
            end
        end
        @(negedge clk);
        tests_run++;
        if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b1 || s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL 8n1 end: tx=%b busy=%b done=%b rdy=%b, expected 1 0 1 1", tx, busy, tx_done, s_ready);
        end
        @(negedge clk);
        tests_run++;
        if (tx_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL 8n1 done_pulse: done=%b one cycle later, expected 0", tx_done);
        end
    endtask

    task automatic test_7e1_parity();
        for (int pt = 0; pt < 2; pt++) begin
            build_frame(8'h55, 1'b1, pt[0], 4'd7, 2'd1, 16'd2);
            accept_byte(8'h55, 1'b1, pt[0], 4'd7, 2'd1, 16'd2, 1'b0);
            for (int c = 0; c < exp_tx.size(); c++) begin
                @(negedge clk);
                tests_run++;
                if (tx !== exp_tx[c] || busy !== 1'b1 || tx_done !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL 7x1 ptype=%0d cycle %0d: tx=%b busy=%b done=%b, expected tx=%b busy=1 done=0",
                             pt, c, tx, busy, tx_done, exp_tx[c]);
                end
                if (c == 16) begin
                    tests_run++;
                    if (tx !== pt[0]) begin
                        tests_failed++;
                        $display("FAIL 7x1 parity_bit ptype=%0d: got %b, expected %b", pt, tx, pt[0]);
                    end
                end
            end
            @(negedge clk);
            tests_run++;
            if (tx_done !== 1'b1 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL 7x1 end ptype=%0d: done=%b busy=%b, expected 1 0", pt, tx_done, busy);
            end
        end
    endtask

    task automatic test_8n2_div0();
        build_frame(8'hFF, 1'b0, 1'b0, 4'd8, 2'd2, 16'd0);
        accept_byte(8'hFF, 1'b0, 1'b0, 4'd8, 2'd2, 16'd0, 1'b0);
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            tests_run++;
            if (tx !== exp_tx[c] || busy !== 1'b1 || tx_done !== 1'b0) begin
                tests_failed++;
                $display("FAIL 8n2_div0 cycle %0d: tx=%b busy=%b done=%b, expected tx=%b busy=1 done=0",
                         c, tx, busy, tx_done, exp_tx[c]);
            end
        end
        @(negedge clk);
        tests_run++;
        if (tx_done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL 8n2_div0 cycle12: done=%b busy=%b tx=%b, expected 1 0 1", tx_done, busy, tx);
        end
    endtask

    task automatic test_back_to_back();
        build_frame(8'h01, 1'b0, 1'b0, 4'd8, 2'd1, 16'd3);
        accept_byte(8'h01, 1'b0, 1'b0, 4'd8, 2'd1, 16'd3, 1'b1);
        // Second byte and a different configuration presented mid-frame.
        s_data            = 8'h80;
        cfg_parity_en     = 1'b1;
        cfg_parity_type   = 1'b1;
        cfg_num_data_bits = 4'd8;
        cfg_num_stop_bits = 2'd2;
        cfg_clk_div       = 16'd3;
        for (int c = 0; c < exp_tx.size(); c++) begin
            @(negedge clk);
            tests_run++;
            if (tx !== exp_tx[c] || busy !== 1'b1 || s_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b frame1 cycle %0d: tx=%b busy=%b rdy=%b, expected tx=%b busy=1 rdy=0",
                         c, tx, busy, s_ready, exp_tx[c]);
            end
        end
        @(negedge clk);
        tests_run++;
        if (tx !== 1'b1 || s_ready !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b idle_gap: tx=%b rdy=%b busy=%b done=%b, expected 1 1 0 1", tx, s_ready, busy, tx_done);
        end
        build_frame(8'h80, 1'b1, 1'b1, 4'd8, 2'd2, 16'd3);
        @(posedge clk);
        #1;
        s_valid           = 1'b0;
        s_data            = 8'hFF;
        cfg_parity_en     = 1'b0;
        cfg_num_data_bits = 4'd5;
        cfg_num_stop_bits = 2'd1;
        cfg_clk_div       = 16'd7;
        for (int c = 0; c < exp_tx.size(); c++) begin
            @(negedge clk);
            tests_run++;
            if (tx !== exp_tx[c] || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b frame2 cycle %0d: tx=%b busy=%b, expected tx=%b busy=1",
                         c, tx, busy, exp_tx[c]);
            end
        end
        @(negedge clk);
        tests_run++;
        if (tx_done !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b frame2 end: done=%b busy=%b, expected 1 0", tx_done, busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        accept_byte(8'h3C, 1'b0, 1'b0, 4'd8, 2'd1, 16'd4, 1'b0);
        repeat (6) @(negedge clk);
        tests_run++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst pre: tx=%b busy=%b, expected 0 1", tx, busy);
        end
        #1 arst = 1'b1;
        #1;
        tests_run++;
        if (tx !== 1'b1 || s_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst async: tx=%b rdy=%b busy=%b, expected 1 1 0", tx, s_ready, busy);
        end
        @(negedge clk);
        arst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            tests_run++;
            if (tx !== 1'b1 || s_ready !== 1'b1 || tx_done !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL midrst idle cycle %0d: tx=%b rdy=%b done=%b busy=%b, expected 1 1 0 0",
                         c, tx, s_ready, tx_done, busy);
            end
        end
        build_frame(8'hC3, 1'b1, 1'b0, 4'd6, 2'd1, 16'd2);
        accept_byte(8'hC3, 1'b1, 1'b0, 4'd6, 2'd1, 16'd2, 1'b0);
        for (int c = 0; c < exp_tx.size(); c++) begin
            @(negedge clk);
            tests_run++;
            if (tx !== exp_tx[c] || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL midrst next cycle %0d: tx=%b busy=%b, expected tx=%b busy=1", c, tx, busy, exp_tx[c]);
            end
        end
        @(negedge clk);
        tests_run++;
        if (tx_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst next end: done=%b, expected 1", tx_done);
        end
    endtask

    task automatic test_random();
        logic [7:0]  d;
        logic        pen;
        logic        pt;
        logic [3:0]  nb;
        logic [1:0]  sb;
        logic [15:0] div;
        for (int k = 0; k < 25; k++) begin
            d   = 8'($urandom);
            pen = 1'($urandom);
            pt  = 1'($urandom);
            nb  = 4'($urandom);
            sb  = 2'($urandom);
            div = 16'($urandom_range(0, 4));
            build_frame(d, pen, pt, nb, sb, div);
            accept_byte(d, pen, pt, nb, sb, div, 1'b0);
            for (int c = 0; c < exp_tx.size(); c++) begin
                @(negedge clk);
                tests_run++;
                if (tx !== exp_tx[c] || busy !== 1'b1 || tx_done !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL random %0d (d=%h pen=%b pt=%b nb=%0d sb=%0d div=%0d) cycle %0d: tx=%b busy=%b done=%b, expected tx=%b",
                             k, d, pen, pt, nb, sb, div, c, tx, busy, tx_done, exp_tx[c]);
                end
            end
            @(negedge clk);
            tests_run++;
            if (tx_done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
                tests_failed++;
                $display("FAIL random %0d end: done=%b busy=%b tx=%b, expected 1 0 1", k, tx_done, busy, tx);
            end
        end
    endtask

    initial begin
        arst              = 1'b1;
        s_valid           = 1'b0;
        s_data            = 8'h00;
        cfg_parity_en     = 1'b0;
        cfg_parity_type   = 1'b0;
        cfg_num_data_bits = 4'd8;
        cfg_num_stop_bits = 2'd1;
        cfg_clk_div       = 16'd1;
        test_reset();
        test_8n1();
        test_7e1_parity();
        test_8n2_div0();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d run %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Transmit stage of the AXI-to-UART bridge. It accepts parallel bytes from the AXI write-data path over a valid/ready handshake. It serializes each byte onto the UART TX line using the uart_config_t-style fields (parity enable/type, data bits, stop bits) and a clock divider. The divider is precomputed by the register block as clk_freq / baudRate.

Parameters:
DIV_WIDTH, 16, width of the clocks-per-bit divider input.
DATA_BITS_MAX, 8, width of the data input; maximum frame data bits.

Ports:
clk  input  1  system clock
arst  input  1  asynchronous, active-high reset
s_data  input  8  byte to transmit; bit 0 is sent first
s_valid  input  1  s_data is valid
s_ready  output  1  block can accept a byte this cycle
cfg_parity_en  input  1  1 = append a parity bit
cfg_parity_type  input  1  0 = even, 1 = odd
cfg_num_data_bits  input  4  data bits per frame
cfg_num_stop_bits  input  2  stop bits per frame
cfg_clk_div  input  DIV_WIDTH  clk cycles per bit
tx  output  1  serial line; idles high
busy  output  1  a frame is in progress
tx_done  output  1  one-cycle pulse at the end of each frame

Behaviour:
- Clock and reset: one clock, clk. Reset arst is asynchronous and active-high.
- Reset values: state=IDLE, tx=1, s_ready=1, busy=0, tx_done=0, all counters 0.
- Reset mid-frame: the frame is aborted immediately. tx returns to 1 asynchronously. The byte in flight is discarded.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - s_ready=1, busy=0, tx=1.
  - On s_valid&&s_ready at a rising edge, latch s_data and all cfg_* inputs into shadow registers, then enter START.
  - The cfg_* inputs are ignored until the next accept. Changing them mid-frame has no effect on the current frame.
- s_ready is a registered output equal to (state==IDLE). It is never 1 outside IDLE.
- Bit timing:
  - Effective divider D = max(cfg_clk_div, 1). A value of 0 is treated as 1.
  - Every bit, including start, each data bit, parity and each stop bit, drives tx for exactly D clk cycles.
  - A down-counter reloads with D-1 on bit entry. The bit ends when the counter reaches 0.
- START: tx=0 for D cycles, then enter DATA.
- DATA:
  - Effective data-bit count N = clamp(cfg_num_data_bits, 5, 8). Values 0..4 are treated as 5; values 9..15 are treated as 8.
  - Bits data[0]..data[N-1] are sent LSB first.
  - After bit N-1, enter PARITY if parity is enabled, else STOP.
- PARITY:
  - Parity bit p = XOR(data[N-1:0]) XOR cfg_parity_type. Even parity gives an even count of ones including p; odd gives an odd count.
  - Only the N transmitted bits contribute to p.
- STOP:
  - tx=1 for S bits, where S = 2 if cfg_num_stop_bits >= 2, else 1 (a value of 0 is treated as 1).
  - After the last stop bit, enter IDLE. tx_done=1 for exactly the cycle in which state returns to IDLE.
- Output timing: tx, busy and tx_done are registered. busy=1 in every state other than IDLE.
- Frame length: D*(1+N+P+S) clk cycles, measured from the first tx=0 cycle to the last stop-bit cycle inclusive. P=1 if parity is enabled, else 0.
- Accept-to-first-start-bit latency: the first tx=0 cycle is the cycle immediately after the accepting edge.
- Back-to-back bytes with s_valid held high: exactly one idle cycle (tx=1, s_ready=1) separates consecutive frames. The next start bit begins on the cycle after that idle cycle.
- s_data and s_valid are sampled only in IDLE. A s_valid raised while busy waits with no loss, provided the source holds it per valid/ready rules.

Test Plan:
- Reset check: assert arst, deassert -> tx=1, s_ready=1, busy=0, tx_done=0.
- 8N1 framing: s_data=0xA5, D=4, 8 data bits, no parity, 1 stop -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; busy high for 40 cycles; tx_done pulses once.
- 7E1 parity: s_data=0x55, N=7, even parity, D=2 -> data bits 1,0,1,0,1,0,1 then parity 0. Same frame with odd parity -> parity bit 1.
- 8N2 with D=0: s_data=0xFF -> D treated as 1; frame is 11 cycles ending with two stop bits; tx_done on the 12th cycle after the accept edge.
- Back-to-back and config isolation: bytes 0x01 and 0x80 with s_valid held high, D=3; cfg changes mid-frame -> first frame unaffected by the cfg change; one idle cycle between frames; second frame uses cfg as sampled at its own accept.
- Reset mid-frame: assert arst during DATA of 0x3C -> tx=1 immediately; s_ready=1 after release; no tx_done pulse; the next byte transmits correctly.
